// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: default address map, MMIO register
// offsets and STATUS bit positions.
package dmem_pkg;

    localparam int unsigned DEF_DEPTH     = 1024;
    localparam logic [31:0] DEF_DATA_BASE = 32'h1001_0000;
    localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF_0000;
    localparam logic [31:0] MMIO_BYTES    = 32'd16;

    typedef enum logic [3:0] {
        OFS_CYCLE  = 4'h0,
        OFS_LEDS   = 4'h4,
        OFS_STATUS = 4'h8,
        OFS_ACCESS = 4'hC
    } mmio_ofs_e;

    localparam int ST_MISALIGN = 0;
    localparam int ST_UNMAPPED = 1;
    localparam int ST_COLLIDE  = 2;
    localparam int ST_PARITY   = 3;
    localparam int ST_BITS     = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-memory bus: the core (master) strobes reads and writes, the responder
// (slave) returns registered read data.
interface dmem_responder_if;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;

    modport master (output MemRead, MemWrite, dAddress, dWriteData, input dReadData);
    modport slave  (input MemRead, MemWrite, dAddress, dWriteData, output dReadData);

endinterface

// File: rtl/dmem_ram_array.sv
// DEPTH x 32 word RAM, one write port and a synchronous read that holds its output
// between reads. DMEM_PARITY_EN adds an even-parity bit per word and a read-side check.
module dmem_ram_array #(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
`ifdef DMEM_PARITY_EN
    input  logic          rst,
    input  logic          i_parity_inject,
`endif
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata,
    output logic          o_parity_err
);

`ifdef DMEM_PARITY_EN
    localparam int unsigned W = 33;
`else
    localparam int unsigned W = 32;
`endif

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rword;
    logic [W-1:0] w_wword;

`ifdef DMEM_PARITY_EN
    assign w_wword = {(^i_wdata) ^ i_parity_inject, i_wdata};
`else
    assign w_wword = i_wdata;
`endif

    // NOTE: the storage array deliberately has no reset so it can map onto block RAM;
    // only control flops that gate visible state are reset.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= w_wword;
        if (i_re) r_rword <= r_mem[i_addr];
    end

    assign o_rdata = r_rword[31:0];

`ifdef DMEM_PARITY_EN
    logic r_chk;

    // The check runs on the registered word, so a parity error is reported the cycle after the read edge.
    always_ff @(posedge clk) begin
        if (rst) r_chk <= 1'b0;
        else     r_chk <= i_re;
    end

    assign o_parity_err = r_chk && (r_rword[32] != ^r_rword[31:0]);
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM window plus CYCLE/LEDS/STATUS/ACCESS MMIO registers.
// Optional DMEM_PARITY_EN adds per-word parity (STATUS bit3) and a parity_inject test port.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter logic [31:0] DATA_BASE = DEF_DATA_BASE,
    parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus,
`ifdef DMEM_PARITY_EN
    input  logic            parity_inject,
`endif
    output logic [31:0]     leds,
    output logic            err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    logic [31:0]        r_cycle;
    logic [31:0]        r_leds;
    logic [31:0]        r_access;
    logic [31:0]        r_mmio_rdata;
    logic [ST_BITS-1:0] r_status;
    logic               r_sel_ram;

    logic [31:0]        w_ram_ofs;
    logic [31:0]        w_mmio_ofs;
    logic [31:0]        w_mmio_rdata;
    logic [31:0]        w_ram_rdata;
    logic [3:0]         w_reg;
    logic [AW-1:0]      w_idx;
    logic               w_any, w_collide, w_misalign, w_ram_hit, w_mmio_hit, w_unmapped, w_valid;
    logic               w_rd, w_rd_ok, w_rd_bad, w_wr_ok, w_ram_we, w_ram_re, w_parity_err;
    logic [ST_BITS-1:0] w_st_set, w_st_clr, w_st_nxt;

    // Unsigned offsets wrap for addresses below a base, so one compare checks both bounds.
    assign w_ram_ofs  = bus.dAddress - DATA_BASE;
    assign w_mmio_ofs = bus.dAddress - MMIO_BASE;
    assign w_ram_hit  = w_ram_ofs < RAM_BYTES;
    assign w_mmio_hit = w_mmio_ofs < MMIO_BYTES;
    assign w_reg      = w_mmio_ofs[3:0];
    assign w_idx      = AW'(w_ram_ofs >> 2);

    assign w_any      = bus.MemRead || bus.MemWrite;
    assign w_collide  = bus.MemRead && bus.MemWrite;
    assign w_misalign = bus.dAddress[1:0] != 2'b00;
    assign w_unmapped = !w_ram_hit && !w_mmio_hit;
    assign w_valid    = !w_misalign && !w_unmapped;

    // A colliding read is dropped; only the write half of the access proceeds.
    assign w_rd     = bus.MemRead && !bus.MemWrite;
    assign w_rd_ok  = w_rd && w_valid;
    assign w_rd_bad = w_rd && !w_valid;
    assign w_wr_ok  = bus.MemWrite && w_valid;
    assign w_ram_we = !rst && w_wr_ok && w_ram_hit;
    assign w_ram_re = !rst && w_rd_ok && w_ram_hit;

    dmem_ram_array #(.DEPTH(DEPTH)) u_ram (
        .clk             (clk),
`ifdef DMEM_PARITY_EN
        .rst             (rst),
        .i_parity_inject (parity_inject),
`endif
        .i_we            (w_ram_we),
        .i_re            (w_ram_re),
        .i_addr          (w_idx),
        .i_wdata         (bus.dWriteData),
        .o_rdata         (w_ram_rdata),
        .o_parity_err    (w_parity_err)
    );

    always_comb begin
        // NOTE: every combinational output gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        w_mmio_rdata = '0;
        w_st_set     = '0;
        w_st_clr     = '0;

        case (w_reg)
            OFS_CYCLE:  w_mmio_rdata = r_cycle;
            OFS_LEDS:   w_mmio_rdata = r_leds;
            OFS_STATUS: w_mmio_rdata = {{(32-ST_BITS){1'b0}}, r_status};
            OFS_ACCESS: w_mmio_rdata = r_access;
            default:    w_mmio_rdata = '0;
        endcase

        w_st_set[ST_MISALIGN] = w_any && w_misalign;
        w_st_set[ST_UNMAPPED] = w_any && w_unmapped;
        w_st_set[ST_COLLIDE]  = w_collide;
        w_st_set[ST_PARITY]   = w_parity_err;

        if (w_wr_ok && w_mmio_hit && (w_reg == OFS_STATUS))
            w_st_clr = bus.dWriteData[ST_BITS-1:0];

        // Set is applied after clear so a new error wins over a same-cycle W1C.
        w_st_nxt = (r_status & ~w_st_clr) | w_st_set;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples
    // the pre-edge values, e.g. a STATUS/ACCESS read returns the value before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle      <= '0;
            r_leds       <= '0;
            r_status     <= '0;
            r_access     <= '0;
            r_sel_ram    <= 1'b0;
            r_mmio_rdata <= '0;
        end else begin
            r_cycle  <= r_cycle + 32'd1;
            r_status <= w_st_nxt;

            if (w_any && w_valid && (r_access != '1))
                r_access <= r_access + 32'd1;

            if (w_wr_ok && w_mmio_hit && (w_reg == OFS_LEDS))
                r_leds <= bus.dWriteData;

            if (w_rd_ok) begin
                r_sel_ram    <= w_ram_hit;
                r_mmio_rdata <= w_ram_hit ? '0 : w_mmio_rdata;
            end else if (w_rd_bad) begin
                r_sel_ram    <= 1'b0;
                r_mmio_rdata <= '0;
            end
        end
    end

    assign bus.dReadData = r_sel_ram ? w_ram_rdata : r_mmio_rdata;
    assign leds          = r_leds;
    assign err           = |r_status;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a randomized run
// against a transaction-level model of the memory map.
`timescale 1ns/1ps
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH     = 1024;
    localparam logic [31:0] DATA_BASE = DEF_DATA_BASE;
    localparam logic [31:0] MMIO_BASE = DEF_MMIO_BASE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] leds;
    logic        err;
`ifdef DMEM_PARITY_EN
    logic        parity_inject = 1'b0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH(DEPTH), .DATA_BASE(DATA_BASE), .MMIO_BASE(MMIO_BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
`ifdef DMEM_PARITY_EN
        .parity_inject (parity_inject),
`endif
        .leds          (leds),
        .err           (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (one call per rising edge) ----------------
    logic [31:0] m_mem [int];
    bit          m_bad [int];
    logic [31:0] m_cycle, m_leds, m_access, m_rdata;
    logic [3:0]  m_status;
    bit          m_known;
    bit          m_par_pending;
    bit          inject_sel = 1'b0;

    function automatic void model_reset();
        m_cycle = 0; m_leds = 0; m_access = 0; m_rdata = 0;
        m_status = 0; m_known = 1'b1; m_par_pending = 1'b0;
    endfunction

    function automatic void model_step(bit rd, bit wr, logic [31:0] a, logic [31:0] d, bit inj);
        longint unsigned la      = a;
        longint unsigned ram_lo  = DATA_BASE;
        longint unsigned ram_hi  = ram_lo + 4 * DEPTH;
        longint unsigned mmio_lo = MMIO_BASE;
        bit in_ram   = (la >= ram_lo) && (la < ram_hi);
        bit in_mmio  = (la >= mmio_lo) && (la < mmio_lo + 16);
        bit misal    = (a % 4) != 0;
        bit ok       = !misal && (in_ram || in_mmio);
        int idx      = in_ram ? int'((la - ram_lo) / 4) : 0;
        int ofs      = in_mmio ? int'(la - mmio_lo) : 0;
        logic [3:0] set = 4'h0;
        logic [3:0] clr = 4'h0;

        // A parity error is flagged on the edge after the offending read.
        if (m_par_pending) set[3] = 1'b1;
        m_par_pending = 1'b0;
        if ((rd || wr) && misal) set[0] = 1'b1;
        if ((rd || wr) && !in_ram && !in_mmio) set[1] = 1'b1;
        if (rd && wr) set[2] = 1'b1;

        if (rd && !wr) begin
            m_known = 1'b1;
            if (!ok) m_rdata = 0;
            else if (in_ram) begin
                if (m_mem.exists(idx)) m_rdata = m_mem[idx];
                else m_known = 1'b0;
                if (m_bad.exists(idx) && m_bad[idx]) m_par_pending = 1'b1;
            end else begin
                case (ofs)
                    0:  m_rdata = m_cycle;
                    4:  m_rdata = m_leds;
                    8:  m_rdata = {28'd0, m_status};
                    default: m_rdata = m_access;
                endcase
            end
        end

        if (wr && ok) begin
            if (in_ram) begin m_mem[idx] = d; m_bad[idx] = inj; end
            else if (ofs == 4) m_leds = d;
            else if (ofs == 8) clr = d[3:0];
        end

        m_status = (m_status & ~clr) | set;
        if ((rd || wr) && ok && m_access != 32'hFFFF_FFFF) m_access = m_access + 1;
        m_cycle = m_cycle + 1;
    endfunction

    // ---------------- drivers: inputs change at negedge, outputs sampled at negedge ----------------
    task automatic do_cycle(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bus.MemRead = rd; bus.MemWrite = wr; bus.dAddress = a; bus.dWriteData = d;
`ifdef DMEM_PARITY_EN
        parity_inject = inject_sel;
`endif
        @(posedge clk);
        model_step(rd, wr, a, d, inject_sel);
        @(negedge clk);
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    endtask

    task automatic do_reset(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bus.MemRead = rd; bus.MemWrite = wr; bus.dAddress = a; bus.dWriteData = d;
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        do_reset(1'b0, 1'b1, MMIO_BASE + 4, 32'hFFFF_FFFF);
        tests_run++;
        if (bus.dReadData !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h want %h", bus.dReadData, 32'h0); end
        tests_run++;
        if (leds !== 32'h0) begin tests_failed++; $display("FAIL reset_leds: got %h want %h", leds, 32'h0); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err); end
        do_cycle(1'b1, 1'b0, MMIO_BASE + 12, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'h0) begin tests_failed++; $display("FAIL reset_access: got %h want %h", bus.dReadData, 32'h0); end
    endtask

    task automatic test_ram_rw();
        do_reset(1'b0, 1'b0, 32'h0, 32'h0);
        do_cycle(1'b0, 1'b1, 32'h1001_0004, 32'hCAFE_F00D);
        do_cycle(1'b1, 1'b0, 32'h1001_0004, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL ram_read: got %h want %h", bus.dReadData, 32'hCAFE_F00D); end
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 1'b0, 32'h0, 32'h0);
            tests_run++;
            if (bus.dReadData !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL ram_hold[%0d]: got %h want %h", i, bus.dReadData, 32'hCAFE_F00D); end
        end
        do_cycle(1'b1, 1'b0, MMIO_BASE + 12, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'd2) begin tests_failed++; $display("FAIL access_count: got %0d want 2", bus.dReadData); end
    endtask

    task automatic test_misalign();
        do_cycle(1'b1, 1'b0, 32'h1001_0002, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'h0) begin tests_failed++; $display("FAIL misalign_rdata: got %h want 0", bus.dReadData); end
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL misalign_err: got %b want 1", err); end
        do_cycle(1'b1, 1'b0, MMIO_BASE + 8, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'h1) begin tests_failed++; $display("FAIL misalign_status: got %h want 1", bus.dReadData); end
        do_cycle(1'b0, 1'b1, MMIO_BASE + 8, 32'h1);
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL w1c_err: got %b want 0", err); end
        do_cycle(1'b1, 1'b0, MMIO_BASE + 8, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'h0) begin tests_failed++; $display("FAIL w1c_status: got %h want 0", bus.dReadData); end
        // A misaligned write into the same word must not land.
        do_cycle(1'b0, 1'b1, 32'h1001_0006, 32'hDEAD_BEEF);
        do_cycle(1'b1, 1'b0, 32'h1001_0004, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL misalign_write: got %h want %h", bus.dReadData, 32'hCAFE_F00D); end
        do_cycle(1'b0, 1'b1, MMIO_BASE + 8, 32'hF);
    endtask

    task automatic test_unmapped();
        do_cycle(1'b0, 1'b1, 32'h1001_0000, 32'h1111_1111);
        do_cycle(1'b0, 1'b1, 32'h1001_0FFC, 32'h1234_5678);
        do_cycle(1'b0, 1'b1, 32'h1001_1000, 32'h5);
        do_cycle(1'b1, 1'b0, MMIO_BASE + 8, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'h2) begin tests_failed++; $display("FAIL unmapped_status: got %h want 2", bus.dReadData); end
        do_cycle(1'b1, 1'b0, 32'h1001_0FFC, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'h1234_5678) begin tests_failed++; $display("FAIL last_word: got %h want %h", bus.dReadData, 32'h1234_5678); end
        do_cycle(1'b1, 1'b0, 32'h1001_0000, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'h1111_1111) begin tests_failed++; $display("FAIL first_word: got %h want %h", bus.dReadData, 32'h1111_1111); end
        do_cycle(1'b1, 1'b0, MMIO_BASE + 16, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'h0) begin tests_failed++; $display("FAIL past_mmio: got %h want 0", bus.dReadData); end
        do_cycle(1'b0, 1'b1, MMIO_BASE + 8, 32'hF);
    endtask

    task automatic test_collision();
        logic [31:0] acc_before;
        do_cycle(1'b1, 1'b0, MMIO_BASE + 12, 32'h0);
        acc_before = m_rdata;
        do_cycle(1'b1, 1'b0, 32'h1001_0004, 32'h0);
        do_cycle(1'b1, 1'b1, MMIO_BASE + 4, 32'hA5);
        tests_run++;
        if (leds !== 32'hA5) begin tests_failed++; $display("FAIL collide_leds: got %h want %h", leds, 32'hA5); end
        tests_run++;
        if (bus.dReadData !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL collide_hold: got %h want %h", bus.dReadData, 32'hCAFE_F00D); end
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL collide_err: got %b want 1", err); end
        do_cycle(1'b1, 1'b0, MMIO_BASE + 12, 32'h0);
        tests_run++;
        if (bus.dReadData !== acc_before + 32'd3) begin tests_failed++; $display("FAIL collide_access: got %0d want %0d", bus.dReadData, acc_before + 32'd3); end
        do_cycle(1'b1, 1'b0, MMIO_BASE + 8, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'h4) begin tests_failed++; $display("FAIL collide_status: got %h want 4", bus.dReadData); end
        do_cycle(1'b0, 1'b1, MMIO_BASE + 8, 32'hF);
    endtask

    // CYCLE read returns the number of rising edges since the reset edge, taken before
    // the read edge's own increment: reset edge -> 0, ten idle edges -> 10.
    task automatic test_cycle();
        do_reset(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (10) do_cycle(1'b0, 1'b0, 32'h0, 32'h0);
        do_cycle(1'b1, 1'b0, MMIO_BASE, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'd10) begin tests_failed++; $display("FAIL cycle_count: got %0d want 10", bus.dReadData); end
        do_cycle(1'b0, 1'b1, MMIO_BASE, 32'h0000_0123);
        do_cycle(1'b1, 1'b0, MMIO_BASE, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'd12) begin tests_failed++; $display("FAIL cycle_after_write: got %0d want 12", bus.dReadData); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL cycle_write_err: got %b want 0", err); end
    endtask

    task automatic test_reset_mid_access();
        do_cycle(1'b0, 1'b1, MMIO_BASE + 4, 32'h77);
        do_cycle(1'b0, 1'b1, 32'h1001_0000, 32'hAAAA_0000);
        do_reset(1'b0, 1'b1, 32'h1001_0000, 32'hBBBB_BBBB);
        tests_run++;
        if (leds !== 32'h0) begin tests_failed++; $display("FAIL rst_leds: got %h want 0", leds); end
        do_cycle(1'b1, 1'b0, 32'h1001_0000, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'hAAAA_0000) begin tests_failed++; $display("FAIL rst_write_dropped: got %h want %h", bus.dReadData, 32'hAAAA_0000); end
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity();
        inject_sel = 1'b1;
        do_cycle(1'b0, 1'b1, 32'h1001_0008, 32'h0F0F_1234);
        inject_sel = 1'b0;
        do_cycle(1'b1, 1'b0, 32'h1001_0008, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'h0F0F_1234) begin tests_failed++; $display("FAIL parity_data: got %h want %h", bus.dReadData, 32'h0F0F_1234); end
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0);
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL parity_err: got %b want 1", err); end
        do_cycle(1'b1, 1'b0, MMIO_BASE + 8, 32'h0);
        tests_run++;
        if (bus.dReadData !== 32'h8) begin tests_failed++; $display("FAIL parity_status: got %h want 8", bus.dReadData); end
        do_cycle(1'b0, 1'b1, MMIO_BASE + 8, 32'hF);
        do_cycle(1'b0, 1'b1, 32'h1001_0008, 32'h0F0F_1234);
        do_cycle(1'b1, 1'b0, 32'h1001_0008, 32'h0);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0);
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL parity_clean: got %b want 0", err); end
    endtask
`endif

    // ---------------- randomized run against the model ----------------
    function automatic logic [31:0] ram_addr(int k);
        int idx = (k < 8) ? k : int'(DEPTH) - 16 + k;
        return DATA_BASE + 32'(4 * idx);
    endfunction

    task automatic test_random();
        logic [31:0] a, d;
        bit rd, wr;
        int op, sel;
        for (int k = 0; k < 16; k++) do_cycle(1'b0, 1'b1, ram_addr(k), $urandom());
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3, 4: a = ram_addr($urandom_range(0, 15));
                5, 6:          a = MMIO_BASE + 32'(4 * $urandom_range(0, 3));
                7:             a = ram_addr($urandom_range(0, 15)) + 32'($urandom_range(1, 3));
                8: begin
                    case ($urandom_range(0, 3))
                        0:       a = DATA_BASE - 32'd4;
                        1:       a = DATA_BASE + 32'(4 * DEPTH);
                        2:       a = MMIO_BASE + 32'd16;
                        default: a = 32'h0;
                    endcase
                end
                default:       a = 32'h2000_0000 | ($urandom() & 32'h0FFF_FFFC);
            endcase
            op = $urandom_range(0, 15);
            rd = (op <= 5) || (op == 12);
            wr = (op >= 6 && op <= 12);
            d  = $urandom();
            do_cycle(rd, wr, a, d);
            if (m_known) begin
                tests_run++;
                if (bus.dReadData !== m_rdata) begin tests_failed++; $display("FAIL rand_rdata[%0d] addr %h: got %h want %h", n, a, bus.dReadData, m_rdata); end
            end
            tests_run++;
            if (leds !== m_leds) begin tests_failed++; $display("FAIL rand_leds[%0d]: got %h want %h", n, leds, m_leds); end
            tests_run++;
            if (err !== (m_status != 4'h0)) begin tests_failed++; $display("FAIL rand_err[%0d]: got %b want %b", n, err, m_status != 4'h0); end
        end
        do_cycle(1'b1, 1'b0, MMIO_BASE + 12, 32'h0);
        tests_run++;
        if (bus.dReadData !== m_rdata) begin tests_failed++; $display("FAIL rand_access: got %0d want %0d", bus.dReadData, m_rdata); end
    endtask

    initial begin
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.dAddress = '0; bus.dWriteData = '0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_ram_rw();
        test_misalign();
        test_unmapped();
        test_collision();
        test_cycle();
        test_reset_mid_access();
`ifdef DMEM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
